// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece rotation controller.
package tetris_pkg;

    typedef enum logic [2:0] {
        ShapeI       = 3'b000,
        ShapeO       = 3'b001,
        ShapeT0      = 3'b010,
        ShapeT1      = 3'b011,
        ShapeS       = 3'b100,
        ShapeZ       = 3'b101,
        ShapeL       = 3'b110,
        ShapeInvalid = 3'b111
    } shape_t;

    typedef logic [1:0] orient_t;

    localparam int unsigned BOARD_W = 10;
    localparam int unsigned BOARD_H = 20;

    typedef logic [4:0] coord_x_t;
    typedef logic [5:0] coord_y_t;

    typedef enum logic [1:0] {
        StIdle,
        StQuery,
        StFinish
    } ctrl_state_t;

endpackage

// File: rtl/rot_bounds_chk.sv
// Combinational legality check of one rotated square: off-board or occupied.
module rot_bounds_chk #(
    parameter int unsigned X_W     = 5,
    parameter int unsigned Y_W     = 6,
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    input  logic           hit,
    output logic           fail
);

    // Unsigned wrap below zero lands far above the board, so one compare covers both edges.
    always_comb begin
        fail = (32'(x) >= BOARD_W) || (32'(y) >= BOARD_H) || hit;
    end

endmodule

// File: rtl/tetris_rotate_ctrl.sv
// Walks the four squares of the falling piece through the rotator, checks each
// candidate against the board and commits or rejects the whole rotation.
module tetris_rotate_ctrl #(
    parameter int unsigned X_W     = 5,
    parameter int unsigned Y_W     = 6,
    parameter int unsigned BOARD_W = 10,
    parameter int unsigned BOARD_H = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rot_req,
    input  logic [2:0]       shape,
    input  logic [1:0]       orient,
    input  logic [4*X_W-1:0] cur_x,
    input  logic [4*Y_W-1:0] cur_y,
    output logic [2:0]       rot_shape,
    output logic [1:0]       rot_orient,
    output logic [1:0]       rot_square_no,
    output logic [X_W-1:0]   rot_x,
    output logic [Y_W-1:0]   rot_y,
    input  logic [X_W-1:0]   rot_x_new,
    input  logic [Y_W-1:0]   rot_y_new,
    input  logic [1:0]       rot_orient_new,
    output logic [X_W-1:0]   occ_x,
    output logic [Y_W-1:0]   occ_y,
    input  logic             occ_hit,
    output logic             busy,
    output logic             done,
    output logic             accepted,
    output logic [4*X_W-1:0] new_x,
    output logic [4*Y_W-1:0] new_y,
    output logic [1:0]       new_orient
);
    import tetris_pkg::*;

    ctrl_state_t      state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic             fail_q, fail_d;
    shape_t           shape_q, shape_d;
    orient_t          orient_q, orient_d;
    logic [4*X_W-1:0] orig_x_q, orig_x_d;
    logic [4*Y_W-1:0] orig_y_q, orig_y_d;
    logic [4*X_W-1:0] cand_x_q, cand_x_d;
    logic [4*Y_W-1:0] cand_y_q, cand_y_d;
    logic [4*X_W-1:0] new_x_q, new_x_d;
    logic [4*Y_W-1:0] new_y_q, new_y_d;
    orient_t          new_orient_q, new_orient_d;
    logic             accepted_q, accepted_d;
    logic             cand_fail;

    rot_bounds_chk #(
        .X_W     (X_W),
        .Y_W     (Y_W),
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H)
    ) u_bounds (
        .x    (rot_x_new),
        .y    (rot_y_new),
        .hit  (occ_hit),
        .fail (cand_fail)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            k_q          <= '0;
            fail_q       <= 1'b0;
            shape_q      <= ShapeI;
            orient_q     <= '0;
            orig_x_q     <= '0;
            orig_y_q     <= '0;
            cand_x_q     <= '0;
            cand_y_q     <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            new_orient_q <= '0;
            accepted_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            fail_q       <= fail_d;
            shape_q      <= shape_d;
            orient_q     <= orient_d;
            orig_x_q     <= orig_x_d;
            orig_y_q     <= orig_y_d;
            cand_x_q     <= cand_x_d;
            cand_y_q     <= cand_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            new_orient_q <= new_orient_d;
            accepted_q   <= accepted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        k_d          = k_q;
        fail_d       = fail_q;
        shape_d      = shape_q;
        orient_d     = orient_q;
        orig_x_d     = orig_x_q;
        orig_y_d     = orig_y_q;
        cand_x_d     = cand_x_q;
        cand_y_d     = cand_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        new_orient_d = new_orient_q;
        accepted_d   = accepted_q;

        unique case (state_q)
            StIdle: begin
                if (rot_req) begin
                    shape_d    = shape_t'(shape);
                    orient_d   = orient;
                    orig_x_d   = cur_x;
                    orig_y_d   = cur_y;
                    fail_d     = 1'b0;
                    k_d        = '0;
                    accepted_d = 1'b0;
                    if (shape_t'(shape) == ShapeInvalid) begin
                        new_x_d      = cur_x;
                        new_y_d      = cur_y;
                        new_orient_d = orient;
                        state_d      = StFinish;
                    end else begin
                        state_d = StQuery;
                    end
                end
            end
            StQuery: begin
                cand_x_d[k_q*X_W +: X_W] = rot_x_new;
                cand_y_d[k_q*Y_W +: Y_W] = rot_y_new;
                fail_d = fail_q | cand_fail;
                k_d    = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = StFinish;
                    // The O piece is rotation-invariant: commit keeps the original squares.
                    if (fail_d || shape_q == ShapeO) begin
                        new_x_d      = orig_x_q;
                        new_y_d      = orig_y_q;
                        new_orient_d = orient_q;
                    end else begin
                        new_x_d      = cand_x_d;
                        new_y_d      = cand_y_d;
                        new_orient_d = rot_orient_new;
                    end
                    accepted_d = ~fail_d;
                end
            end
            StFinish: begin
                accepted_d = 1'b0;
                k_d        = '0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rot_shape     = shape_q;
        rot_orient    = orient_q;
        rot_square_no = k_q;
        rot_x         = orig_x_q[k_q*X_W +: X_W];
        rot_y         = orig_y_q[k_q*Y_W +: Y_W];
        occ_x         = rot_x_new;
        occ_y         = rot_y_new;
        busy          = (state_q != StIdle);
        done          = (state_q == StFinish);
        accepted      = accepted_q;
        new_x         = new_x_q;
        new_y         = new_y_q;
        new_orient    = new_orient_q;
    end

endmodule

// File: tb/tb_tetris_rotate_ctrl.sv
// Directed bench for tetris_rotate_ctrl; a table-driven stand-in plays rotator and board RAM.
module tb_tetris_rotate_ctrl;

    localparam int X_W = 5;
    localparam int Y_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             rot_req;
    logic [2:0]       shape;
    logic [1:0]       orient;
    logic [4*X_W-1:0] cur_x;
    logic [4*Y_W-1:0] cur_y;
    logic [2:0]       rot_shape;
    logic [1:0]       rot_orient;
    logic [1:0]       rot_square_no;
    logic [X_W-1:0]   rot_x;
    logic [Y_W-1:0]   rot_y;
    logic [X_W-1:0]   rot_x_new;
    logic [Y_W-1:0]   rot_y_new;
    logic [1:0]       rot_orient_new;
    logic [X_W-1:0]   occ_x;
    logic [Y_W-1:0]   occ_y;
    logic             occ_hit;
    logic             busy;
    logic             done;
    logic             accepted;
    logic [4*X_W-1:0] new_x;
    logic [4*Y_W-1:0] new_y;
    logic [1:0]       new_orient;

    logic [4*X_W-1:0] tx;
    logic [4*Y_W-1:0] ty;
    logic [1:0]       to;
    logic [3:0]       hit_mask;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rot_x_new      = tx[int'(rot_square_no)*X_W +: X_W];
    assign rot_y_new      = ty[int'(rot_square_no)*Y_W +: Y_W];
    assign rot_orient_new = to;
    assign occ_hit        = hit_mask[rot_square_no];

    tetris_rotate_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .rot_req        (rot_req),
        .shape          (shape),
        .orient         (orient),
        .cur_x          (cur_x),
        .cur_y          (cur_y),
        .rot_shape      (rot_shape),
        .rot_orient     (rot_orient),
        .rot_square_no  (rot_square_no),
        .rot_x          (rot_x),
        .rot_y          (rot_y),
        .rot_x_new      (rot_x_new),
        .rot_y_new      (rot_y_new),
        .rot_orient_new (rot_orient_new),
        .occ_x          (occ_x),
        .occ_y          (occ_y),
        .occ_hit        (occ_hit),
        .busy           (busy),
        .done           (done),
        .accepted       (accepted),
        .new_x          (new_x),
        .new_y          (new_y),
        .new_orient     (new_orient)
    );

    function automatic logic [4*X_W-1:0] px(input int a, input int b, input int c, input int d);
        return {5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    function automatic logic [4*Y_W-1:0] py(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    // Issues one request and waits (bounded) for done; lat counts cycles after the accept edge.
    task automatic run_op(input logic [2:0] sh, input logic [1:0] ori,
                          input logic [4*X_W-1:0] cx, input logic [4*Y_W-1:0] cy,
                          output int lat, output logic acc, output logic [4*X_W-1:0] nx,
                          output logic [4*Y_W-1:0] ny, output logic [1:0] no);
        lat = -1; acc = 1'bx; nx = 'x; ny = 'x; no = 'x;
        @(negedge clk);
        shape = sh; orient = ori; cur_x = cx; cur_y = cy; rot_req = 1'b1;
        @(negedge clk);
        rot_req = 1'b0; cur_x = '1; cur_y = '1; shape = 3'b000; orient = 2'b11;
        for (int c = 1; c <= 8; c++) begin
            if (done) begin
                lat = c; acc = accepted; nx = new_x; ny = new_y; no = new_orient;
                break;
            end
            if (c <= 4) begin
                n_cmp++;
                if (rot_x !== cx[(c-1)*X_W +: X_W] || rot_y !== cy[(c-1)*Y_W +: Y_W]) begin
                    n_err++;
                    $display("FAIL query_addr c=%0d got (%0d,%0d) want (%0d,%0d)", c, rot_x, rot_y,
                             cx[(c-1)*X_W +: X_W], cy[(c-1)*Y_W +: Y_W]);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic check_op(input string name, input int lat, input logic acc,
                            input logic [4*X_W-1:0] nx, input logic [4*Y_W-1:0] ny,
                            input logic [1:0] no, input int e_lat, input logic e_acc,
                            input logic [4*X_W-1:0] e_nx, input logic [4*Y_W-1:0] e_ny,
                            input logic [1:0] e_no);
        n_cmp++;
        if (lat !== e_lat || acc !== e_acc || nx !== e_nx || ny !== e_ny || no !== e_no) begin
            n_err++;
            $display("FAIL %s got lat=%0d acc=%b x=%h y=%h o=%b want lat=%0d acc=%b x=%h y=%h o=%b",
                     name, lat, acc, nx, ny, no, e_lat, e_acc, e_nx, e_ny, e_no);
        end
    endtask

    task automatic check_idle_zero(input string name);
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0 || accepted !== 1'b0 || new_x !== '0 ||
            new_y !== '0 || new_orient !== '0 || rot_shape !== '0 || rot_orient !== '0 ||
            rot_square_no !== '0 || rot_x !== '0 || rot_y !== '0) begin
            n_err++;
            $display("FAIL %s got busy=%b done=%b acc=%b x=%h y=%h o=%b sh=%b sq=%0d want all 0",
                     name, busy, done, accepted, new_x, new_y, new_orient, rot_shape,
                     rot_square_no);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rot_req = 1'b0; shape = '0; orient = '0; cur_x = '0; cur_y = '0;
        tx = '0; ty = '0; to = '0; hit_mask = '0;
        #12;
        check_idle_zero("reset_held");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_idle_zero("reset_released");
    endtask

    task automatic test_i_piece();
        int lat; logic acc; logic [4*X_W-1:0] nx; logic [4*Y_W-1:0] ny; logic [1:0] no;
        tx = px(5, 5, 5, 5); ty = py(4, 5, 6, 7); to = 2'b01; hit_mask = 4'b0000;
        run_op(3'b000, 2'b00, px(4, 5, 6, 7), py(5, 5, 5, 5), lat, acc, nx, ny, no);
        check_op("i_piece", lat, acc, nx, ny, no, 5, 1'b1, px(5, 5, 5, 5), py(4, 5, 6, 7), 2'b01);
    endtask

    task automatic test_wrap();
        int lat; logic acc; logic [4*X_W-1:0] nx; logic [4*Y_W-1:0] ny; logic [1:0] no;
        tx = px(31, 30, 0, 1); ty = py(5, 5, 5, 5); to = 2'b11; hit_mask = 4'b0000;
        run_op(3'b000, 2'b10, px(0, 1, 2, 3), py(5, 5, 5, 5), lat, acc, nx, ny, no);
        check_op("x_wrap", lat, acc, nx, ny, no, 5, 1'b0, px(0, 1, 2, 3), py(5, 5, 5, 5), 2'b10);
        tx = px(4, 4, 5, 5); ty = py(0, 63, 1, 2); to = 2'b01;
        run_op(3'b100, 2'b00, px(4, 5, 5, 6), py(1, 1, 0, 0), lat, acc, nx, ny, no);
        check_op("y_wrap", lat, acc, nx, ny, no, 5, 1'b0, px(4, 5, 5, 6), py(1, 1, 0, 0), 2'b00);
    endtask

    task automatic test_boundary();
        int lat; logic acc; logic [4*X_W-1:0] nx; logic [4*Y_W-1:0] ny; logic [1:0] no;
        hit_mask = 4'b0000; to = 2'b01;
        tx = px(9, 9, 8, 0); ty = py(19, 18, 19, 0);
        run_op(3'b110, 2'b00, px(3, 3, 3, 4), py(17, 18, 19, 19), lat, acc, nx, ny, no);
        check_op("edge_ok", lat, acc, nx, ny, no, 5, 1'b1, px(9, 9, 8, 0), py(19, 18, 19, 0), 2'b01);
        tx = px(10, 9, 8, 0);
        run_op(3'b110, 2'b00, px(3, 3, 3, 4), py(17, 18, 19, 19), lat, acc, nx, ny, no);
        check_op("x_eq_w", lat, acc, nx, ny, no, 5, 1'b0, px(3, 3, 3, 4), py(17, 18, 19, 19), 2'b00);
        tx = px(9, 9, 8, 0); ty = py(19, 18, 19, 20);
        run_op(3'b110, 2'b00, px(3, 3, 3, 4), py(17, 18, 19, 19), lat, acc, nx, ny, no);
        check_op("y_eq_h", lat, acc, nx, ny, no, 5, 1'b0, px(3, 3, 3, 4), py(17, 18, 19, 19), 2'b00);
    endtask

    task automatic test_occupied();
        int lat; logic acc; logic [4*X_W-1:0] nx; logic [4*Y_W-1:0] ny; logic [1:0] no;
        tx = px(5, 5, 5, 5); ty = py(4, 5, 6, 7); to = 2'b01; hit_mask = 4'b0100;
        run_op(3'b000, 2'b00, px(4, 5, 6, 7), py(5, 5, 5, 5), lat, acc, nx, ny, no);
        check_op("occ_k2", lat, acc, nx, ny, no, 5, 1'b0, px(4, 5, 6, 7), py(5, 5, 5, 5), 2'b00);
        hit_mask = 4'b0000;
    endtask

    task automatic test_o_piece();
        int lat; logic acc; logic [4*X_W-1:0] nx; logic [4*Y_W-1:0] ny; logic [1:0] no;
        tx = px(5, 5, 4, 4); ty = py(0, 1, 0, 1); to = 2'b01; hit_mask = 4'b0000;
        run_op(3'b001, 2'b00, px(4, 5, 4, 5), py(0, 0, 1, 1), lat, acc, nx, ny, no);
        check_op("o_piece", lat, acc, nx, ny, no, 5, 1'b1, px(4, 5, 4, 5), py(0, 0, 1, 1), 2'b00);
    endtask

    task automatic test_invalid();
        int lat; logic acc; logic [4*X_W-1:0] nx; logic [4*Y_W-1:0] ny; logic [1:0] no;
        tx = px(5, 5, 5, 5); ty = py(4, 5, 6, 7); to = 2'b01; hit_mask = 4'b0000;
        run_op(3'b111, 2'b10, px(1, 2, 3, 4), py(1, 1, 1, 1), lat, acc, nx, ny, no);
        check_op("invalid", lat, acc, nx, ny, no, 1, 1'b0, px(1, 2, 3, 4), py(1, 1, 1, 1), 2'b10);
    endtask

    task automatic test_ignored_req();
        int n_done = 0;
        int done_at = -1;
        logic acc_at;
        tx = px(5, 5, 5, 5); ty = py(4, 5, 6, 7); to = 2'b01; hit_mask = 4'b0000;
        @(negedge clk);
        shape = 3'b000; orient = 2'b00; cur_x = px(4, 5, 6, 7); cur_y = py(5, 5, 5, 5);
        rot_req = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            // A stray invalid-shape request would finish in one cycle if wrongly taken.
            rot_req = (c == 2 || c == 5);
            shape   = 3'b111;
            if (done) begin
                n_done++;
                if (done_at < 0) begin done_at = c; acc_at = accepted; end
            end
        end
        rot_req = 1'b0;
        n_cmp++;
        if (n_done !== 1 || done_at !== 5 || acc_at !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_req got dones=%0d at=%0d acc=%b want dones=1 at=5 acc=1",
                     n_done, done_at, acc_at);
        end
    endtask

    task automatic test_back_to_back();
        int lat; logic acc; logic [4*X_W-1:0] nx; logic [4*Y_W-1:0] ny; logic [1:0] no;
        tx = px(5, 5, 5, 5); ty = py(4, 5, 6, 7); to = 2'b01; hit_mask = 4'b0000;
        run_op(3'b000, 2'b00, px(4, 5, 6, 7), py(5, 5, 5, 5), lat, acc, nx, ny, no);
        check_op("b2b_first", lat, acc, nx, ny, no, 5, 1'b1, px(5, 5, 5, 5), py(4, 5, 6, 7), 2'b01);
        // run_op requests on the very next negedge, i.e. the cycle right after done.
        tx = px(6, 5, 4, 3); ty = py(5, 5, 5, 5); to = 2'b10;
        run_op(3'b000, 2'b01, px(5, 5, 5, 5), py(4, 5, 6, 7), lat, acc, nx, ny, no);
        check_op("b2b_second", lat, acc, nx, ny, no, 5, 1'b1, px(6, 5, 4, 3), py(5, 5, 5, 5), 2'b10);
    endtask

    task automatic test_reset_mid();
        int n_done = 0;
        tx = px(5, 5, 5, 5); ty = py(4, 5, 6, 7); to = 2'b01; hit_mask = 4'b0000;
        @(negedge clk);
        shape = 3'b000; orient = 2'b00; cur_x = px(4, 5, 6, 7); cur_y = py(5, 5, 5, 5);
        rot_req = 1'b1;
        @(negedge clk);
        rot_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_idle_zero("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        n_cmp++;
        if (n_done !== 0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_done got dones=%0d busy=%b want dones=0 busy=0", n_done, busy);
        end
    endtask

    initial begin
        test_reset();
        test_i_piece();
        test_wrap();
        test_boundary();
        test_occupied();
        test_o_piece();
        test_invalid();
        test_ignored_req();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
